// File: rtl/fb_scan_arbiter.sv
// Framebuffer RAM arbiter: prefetches RGB565 scan-out pixels into a register FIFO and gives idle RAM cycles to a writer.
// Optional macro FBARB_UNDERFLOW_EN builds the sticky underflow detector; without it o_underflow is tied low.
module fb_scan_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 19,
    parameter int NPIX  = 307200
) (
    input  logic                     i_pixclk,
    input  logic                     i_reset,
    input  logic                     i_rd,
    input  logic                     i_newframe,
    output logic [AW-1:0]            o_ram_addr,
    output logic                     o_ram_we,
    output logic [15:0]              o_ram_wdata,
    input  logic [15:0]              i_ram_rdata,
    input  logic                     i_wr_req,
    input  logic [AW-1:0]            i_wr_addr,
    input  logic [15:0]              i_wr_data,
    output logic                     o_wr_ack,
    output logic [7:0]               o_red,
    output logic [7:0]               o_grn,
    output logic [7:0]               o_blu,
    output logic                     o_underflow,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(NPIX + 1);
    localparam logic [CW-1:0] NPIX_C  = CW'(NPIX);
    localparam logic [LW-1:0] DEPTH_C = LW'(DEPTH);

    logic [AW-1:0] fetch_addr;
    logic [CW-1:0] fetch_cnt;
    logic          rvalid;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;

    logic          scan_rd;
    logic          wr_grant;
    logic          push;
    logic          pop;
    logic          empty;
    logic [15:0]   head;

    // Writer handshake: i_wr_req (valid) stays high with stable addr/data until o_wr_ack (ready);
    // the write happens in exactly the cycle both are high. Scan reads always win the port.
    always_comb begin
        scan_rd  = !i_reset && !i_newframe && (fetch_cnt < NPIX_C)
                   && ((count + LW'(rvalid)) < DEPTH_C);
        wr_grant = !i_reset && !scan_rd && i_wr_req;
        push     = rvalid && !i_newframe;
        pop      = i_rd && (count != '0) && !i_newframe;
        empty    = (count == '0);
        head     = mem[rd_ptr];
    end

    always_comb begin
        o_ram_addr  = addr_q;
        o_ram_we    = 1'b0;
        o_ram_wdata = wdata_q;
        o_wr_ack    = 1'b0;
        if (scan_rd) begin
            o_ram_addr = fetch_addr;
        end else if (wr_grant) begin
            o_ram_addr  = i_wr_addr;
            o_ram_we    = 1'b1;
            o_ram_wdata = i_wr_data;
            o_wr_ack    = 1'b1;
        end
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            fetch_addr <= '0;
            fetch_cnt  <= '0;
            rvalid     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            addr_q  <= o_ram_addr;
            wdata_q <= o_ram_wdata;
            rvalid  <= scan_rd;
            if (i_newframe) begin
                // Flush: the data for a read issued last cycle is dropped with the FIFO contents.
                fetch_addr <= '0;
                fetch_cnt  <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
            end else begin
                if (scan_rd) begin
                    fetch_addr <= fetch_addr + 1'b1;
                    fetch_cnt  <= fetch_cnt + 1'b1;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge i_pixclk) begin
        if (push) mem[wr_ptr] <= i_ram_rdata;
    end

    // Empty FIFO shows black; 565 fields are widened by replicating their top bits.
    always_comb begin
        o_red = 8'd0;
        o_grn = 8'd0;
        o_blu = 8'd0;
        if (!empty) begin
            o_red = {head[15:11], head[15:13]};
            o_grn = {head[10:5],  head[10:9]};
            o_blu = {head[4:0],   head[4:2]};
        end
    end

    assign o_level = count;

`ifdef FBARB_UNDERFLOW_EN
    logic armed;
    logic underflow_q;

    // Detection only starts after the first frame boundary, so power-up pops are harmless.
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            armed       <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (i_newframe) armed <= 1'b1;
            if (i_rd && empty && armed) underflow_q <= 1'b1;
        end
    end

    assign o_underflow = underflow_q;
`else
    assign o_underflow = 1'b0;
`endif

endmodule
